// File: rtl/load_store_unit_if.sv
// Core-side request/response and RAM-side word port of the load/store unit.
// The master side is the core plus RAM; the slave side is the load_store_unit.
interface load_store_unit_if #(
   parameter int dataW = 32
);
   logic             req;
   logic             we;
   logic [2:0]       funct3;
   logic [dataW-1:0] addr;
   logic [dataW-1:0] wdata;
   logic             ready;
   logic             done;
   logic             err;
   logic [dataW-1:0] rdata;
   logic [dataW-1:0] ramAddr;
   logic             ramWrite;
   logic [dataW-1:0] ramWdata;
   logic [dataW-1:0] ramRdata;

   modport master (
      output req, we, funct3, addr, wdata, ramRdata,
      input  ready, done, err, rdata, ramAddr, ramWrite, ramWdata
   );

   modport slave (
      input  req, we, funct3, addr, wdata, ramRdata,
      output ready, done, err, rdata, ramAddr, ramWrite, ramWdata
   );
endinterface

// File: rtl/load_store_unit.sv
// Sequential RV32I load/store unit: one request at a time, sub-word stores by read-modify-write.
// Latency accept->done: reject 1, load/SW 2, SB/SH 3; requests are only taken while ready (IDLE).
module load_store_unit #(
   parameter int dataW       = 32,
   parameter int RAMAddrSize = 16
) (
   input logic             clock,
   input logic             reset,
   load_store_unit_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RMW_READ,
      WRITE,
      RESP
   } state_t;

   state_t      state;
   logic [2:0]  funct3_q;
   logic [1:0]  lane_q;
   logic [15:0] wdata_q;

   logic [dataW-1:0] le;
   logic [dataW-1:0] merged;
   logic [dataW-1:0] load_val;
   logic [dataW-1:0] word_p3;
   logic [7:0]       byte_v;
   logic [15:0]      half_v;
   logic             bad_funct3;
   logic             bad_range;
   logic             bad_align;
   logic             acc_ok;

   // RAM presents the lowest address in the top byte, so swap to little-endian.
   function automatic logic [dataW-1:0] bswap(input logic [dataW-1:0] x);
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
   endfunction

   always_comb begin
      bad_funct3 = 1'b0;
      if (bus.we) begin
         bad_funct3 = !(bus.funct3 == 3'b000 || bus.funct3 == 3'b001 || bus.funct3 == 3'b010);
      end else begin
         bad_funct3 = (bus.funct3 == 3'b011 || bus.funct3 == 3'b110 || bus.funct3 == 3'b111);
      end
      bad_range = |bus.addr[dataW-1:RAMAddrSize];
      bad_align = 1'b0;
      if (bus.funct3[1:0] == 2'b01) begin
         bad_align = bus.addr[0];
      end else if (bus.funct3[1:0] == 2'b10) begin
         bad_align = |bus.addr[1:0];
      end
      acc_ok = !bad_funct3 && !bad_range && !bad_align;
      // Word base plus 3 only touches the two cleared low bits, so no carry exists.
      word_p3 = {bus.addr[dataW-1:2], 2'b11};
   end

   always_comb begin
      le     = bswap(bus.ramRdata);
      byte_v = le[{lane_q, 3'b000} +: 8];
      half_v = le[{lane_q[1], 4'b0000} +: 16];
      case (funct3_q)
         3'b000:  load_val = {{24{byte_v[7]}}, byte_v};
         3'b100:  load_val = {24'h000000, byte_v};
         3'b001:  load_val = {{16{half_v[15]}}, half_v};
         3'b101:  load_val = {16'h0000, half_v};
         default: load_val = le;
      endcase
      merged = le;
      if (funct3_q[1:0] == 2'b00) begin
         merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      end else begin
         merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         funct3_q     <= 3'b000;
         lane_q       <= 2'b00;
         wdata_q      <= 16'h0000;
         bus.ready    <= 1'b1;
         bus.done     <= 1'b0;
         bus.err      <= 1'b0;
         bus.rdata    <= '0;
         bus.ramAddr  <= '0;
         bus.ramWrite <= 1'b0;
         bus.ramWdata <= '0;
      end else begin
         bus.done     <= 1'b0;
         bus.err      <= 1'b0;
         bus.ramWrite <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.req) begin
                  funct3_q  <= bus.funct3;
                  lane_q    <= bus.addr[1:0];
                  wdata_q   <= bus.wdata[15:0];
                  bus.ready <= 1'b0;
                  if (!acc_ok) begin
                     state    <= RESP;
                     bus.done <= 1'b1;
                     bus.err  <= 1'b1;
                  end else if (!bus.we) begin
                     state       <= LOAD;
                     bus.ramAddr <= word_p3;
                  end else if (bus.funct3 == 3'b010) begin
                     state        <= WRITE;
                     bus.ramAddr  <= word_p3;
                     bus.ramWrite <= 1'b1;
                     bus.ramWdata <= bswap(bus.wdata);
                  end else begin
                     state       <= RMW_READ;
                     bus.ramAddr <= word_p3;
                  end
               end
            end
            LOAD: begin
               state       <= RESP;
               bus.rdata   <= load_val;
               bus.done    <= 1'b1;
               bus.ramAddr <= '0;
            end
            RMW_READ: begin
               state        <= WRITE;
               bus.ramWrite <= 1'b1;
               bus.ramWdata <= bswap(merged);
            end
            WRITE: begin
               state        <= RESP;
               bus.done     <= 1'b1;
               bus.ramAddr  <= '0;
               bus.ramWdata <= '0;
            end
            RESP: begin
               state     <= IDLE;
               bus.ready <= 1'b1;
            end
            default: begin
               state     <= IDLE;
               bus.ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequential load/store unit between the RISC-V32I core's memory stage and the zero-delay byte RAM. It accepts one LB/LH/LW/LBU/LHU/SB/SH/SW request at a time and translates it into aligned RAM word accesses. Sub-word stores are done by read-modify-write, and loaded data is returned sign- or zero-extended. Misaligned, out-of-range and illegal requests are rejected without touching RAM.

## Interface

- dataW, 32, core data/address width; only 32 is supported.
- RAMAddrSize, 16, RAM byte-address width; valid byte addresses are 0 .. 2^RAMAddrSize-1.

- clock  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  request strobe; sampled only when ready=1.
- we  in  1  1=store, 0=load.
- funct3  in  3  RV32I size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  in  dataW  byte address of the access.
- wdata  in  dataW  store data; the low byte, half or word is used.
- ready  out  1  high in IDLE only.
- done  out  1  one-cycle pulse ending every accepted request.
- err  out  1  valid with done; 1 means the request was rejected.
- rdata  out  dataW  load result, valid with done.
- ramAddr  out  dataW  RAM address; the RAM returns bits [7:0] from ramAddr and bits [31:24] from ramAddr-3.
- ramWrite  out  1  RAM write enable.
- ramWdata  out  dataW  RAM write data.
- ramRdata  in  dataW  RAM combinational read data.

## Operation

- States: IDLE, LOAD, RMW_READ, WRITE, RESP.
- Accept: rising edge with state=IDLE and req=1. At this edge, addr, funct3, we and wdata are registered. Requests outside IDLE are ignored, not queued.
- Checks at accept, in priority order:
  - illegal funct3 (loads: 011/110/111; stores: anything except 000/001/010);
  - out of range: addr[dataW-1:RAMAddrSize] != 0;
  - misaligned: H/HU with addr[0]=1, W with addr[1:0]!=0.
  - Any failure goes IDLE→RESP with err=1 and no RAM access.
- Address mapping:
  - W = addr with bits [1:0] cleared.
  - ramAddr = W+3 in LOAD, RMW_READ and WRITE; ramAddr = 0 otherwise.
  - Little-endian word le = byteswap(ramRdata), i.e. mem[W] is le[7:0].
  - Lane k = addr[1:0].
- Load: IDLE→LOAD→RESP.
  - LOAD registers rdata: le byte k, le half k/2, or le.
  - B and H sign-extend; BU and HU zero-extend.
- SW: IDLE→WRITE→RESP. WRITE drives ramWrite=1 and ramWdata = byteswap(wdata).
- SB/SH: IDLE→RMW_READ→WRITE→RESP.
  - RMW_READ registers le.
  - Lane k (SB) or lanes k,k+1 (SH) are replaced with wdata[7:0] or wdata[15:0].
  - WRITE writes the byteswapped merged word.
- RESP: done=1 and err valid for one cycle; rdata valid on loads. Next state is IDLE unconditionally.
- rdata holds its last load value until the next load completes. Stores and errors leave rdata unchanged.
- ramWrite is decoded from state only, so exactly one write cycle occurs per legal store.

## Timing

- Reset values: state=IDLE, ready=1, done=0, err=0, rdata=0, ramWrite=0, ramAddr=0, ramWdata=0.
- Reset is asynchronous. Asserting it mid-operation aborts immediately: ramWrite drops in the same cycle, no done pulse is produced, and partial RMW leaves RAM unmodified.
- Latency from the accepting edge to done high:
  - rejected request: 1 cycle;
  - load: 2 cycles;
  - SW: 2 cycles;
  - SB/SH: 3 cycles.
- ready goes low the cycle after acceptance and returns high the cycle after done.
- Back-to-back requests therefore have a minimum issue interval of (latency+1) cycles.
- Address arithmetic W+3 is 32-bit. It cannot wrap, because range is checked first; the highest legal word is 2^RAMAddrSize-4, which maps to ramAddr 2^RAMAddrSize-1.
- req held high continuously is accepted again on the first IDLE edge.

## Test plan

- Reset, then SW addr=0x100 wdata=0x11223344 → one ramWrite cycle with ramAddr=0x103 and ramWdata=0x44332211. Then LW 0x100 → done 2 cycles after accept, rdata=0x11223344, err=0.
- After the above, SB addr=0x102 wdata=0xAA → 3-cycle latency. Then LW 0x100 → 0x11AA3344, LB 0x102 → 0xFFFFFFAA, LBU 0x102 → 0x000000AA.
- SH addr=0x100 wdata=0x8001, then LH 0x100 → 0xFFFF8001 and LHU 0x100 → 0x00008001.
- Reject cases: LW 0x101, LH 0x103, SW 0x10000, store funct3=100 → each gives done+err 1 cycle after accept, no ramWrite, rdata unchanged.
- Boundary: SW 0xFFFC wdata=0xDEADBEEF → ramAddr=0xFFFF. Then LW 0xFFFC → 0xDEADBEEF.
- Reset asserted during RMW_READ of SB 0x200 → no ramWrite and no done. Subsequent LW 0x200 returns the pre-store value; a new req is accepted right after reset release.
